// File: rtl/filter_output_formatter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : filter_output_formatter
// Brief    : Rounds, scales and saturates the FIR accumulator stream into a
//            first-word-fall-through FIFO with sticky saturate/drop flags.
//            Define FORMATTER_ROUND_CONVERGENT_EN for round-half-to-even.
// Revision : 1.0 - initial release
// ============================================================================
module filter_output_formatter #(
    parameter int InWidth   = 48,
    parameter int OutWidth  = 18,
    parameter int Shift     = 17,
    parameter int FifoDepth = 8
) (
    input  logic                          Clk_i,
    input  logic                          Rstn_i,
    input  logic signed [InWidth-1:0]     Data_i,
    input  logic                          DataValid_i,
    output logic signed [OutWidth-1:0]    Data_o,
    output logic                          DataValid_o,
    input  logic                          DataReady_i,
    output logic [$clog2(FifoDepth):0]    Level_o,
    output logic                          Sat_o,
    output logic                          Overflow_o,
    input  logic                          ClearFlags_i
);

    localparam int c_aw  = $clog2(FifoDepth);
    localparam int c_pw  = c_aw + 1;
    localparam int c_r1w = InWidth + 1 - Shift;
    localparam logic [InWidth:0] c_half = (InWidth+1)'(1) << (Shift - 1);

    // ------------------------------------------------------------------
    // Stage 1: round and arithmetic shift on a sign-extended sample
    // ------------------------------------------------------------------
    logic signed [InWidth:0]   w_ext;
    logic signed [InWidth:0]   w_rnd;
    logic signed [InWidth:0]   w_sum;
    logic signed [c_r1w-1:0]   w_shr;
    logic signed [c_r1w-1:0]   r_r1;
    logic                      r_v1;

    assign w_ext = {Data_i[InWidth-1], Data_i};

`ifdef FORMATTER_ROUND_CONVERGENT_EN
    // Exact tie with an even kept LSB stays put; everything else rounds up.
    assign w_rnd = ((w_ext[Shift-1:0] == c_half[Shift-1:0]) && !w_ext[Shift])
                   ? '0 : $signed(c_half);
`else
    assign w_rnd = $signed(c_half);
`endif

    assign w_sum = w_ext + w_rnd;
    assign w_shr = c_r1w'(w_sum >>> Shift);

    // ------------------------------------------------------------------
    // Stage 2: saturate to the signed output range
    // ------------------------------------------------------------------
    logic [c_r1w-OutWidth:0]   w_hi;
    logic                      w_fits;
    logic [OutWidth-1:0]       w_sat_val;
    logic [OutWidth-1:0]       r_r2;
    logic                      r_v2;

    assign w_hi      = r_r1[c_r1w-1:OutWidth-1];
    assign w_fits    = (&w_hi) | ~(|w_hi);
    assign w_sat_val = w_fits           ? r_r1[OutWidth-1:0] :
                       r_r1[c_r1w-1]    ? {1'b1, {(OutWidth-1){1'b0}}} :
                                          {1'b0, {(OutWidth-1){1'b1}}};

    // Datapath registers carry no reset; only the valids qualify them.
    always_ff @(posedge Clk_i) begin
        if (DataValid_i) begin
            r_r1 <= w_shr;
        end
        if (r_v1) begin
            r_r2 <= w_sat_val;
        end
    end

    // ------------------------------------------------------------------
    // FIFO with wrap-bit pointers
    // ------------------------------------------------------------------
    logic [OutWidth-1:0]       r_mem [FifoDepth];
    logic [c_pw-1:0]           r_wr_ptr;
    logic [c_pw-1:0]           r_rd_ptr;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;
    logic                      w_sat_evt;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                       (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
    assign w_pop     = !w_empty && DataReady_i;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push    = r_v2 && (!w_full || w_pop);
    assign w_drop    = r_v2 && w_full && !w_pop;
    assign w_sat_evt = r_v1 && !w_fits;

    always_ff @(posedge Clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= r_r2;
        end
    end

    always_ff @(posedge Clk_i or negedge Rstn_i) begin
        if (!Rstn_i) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            Sat_o      <= 1'b0;
            Overflow_o <= 1'b0;
        end else begin
            r_v1 <= DataValid_i;
            r_v2 <= r_v1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A new event beats a coincident clear.
            if (w_sat_evt) begin
                Sat_o <= 1'b1;
            end else if (ClearFlags_i) begin
                Sat_o <= 1'b0;
            end
            if (w_drop) begin
                Overflow_o <= 1'b1;
            end else if (ClearFlags_i) begin
                Overflow_o <= 1'b0;
            end
        end
    end

    assign Level_o     = r_wr_ptr - r_rd_ptr;
    assign DataValid_o = !w_empty;
    assign Data_o      = w_empty ? '0 : $signed(r_mem[r_rd_ptr[c_aw-1:0]]);

endmodule
`default_nettype wire

// File: tb/tb_filter_output_formatter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_filter_output_formatter
// Brief    : Scoreboard bench for filter_output_formatter (Shift=17,
//            OutWidth=18, FifoDepth=8); honours FORMATTER_ROUND_CONVERGENT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_output_formatter;

    localparam longint SC   = 131072;
    localparam longint HALF = 65536;
    localparam longint MAXV = 131071;
    localparam longint MINV = -131072;
    localparam int     DEPTH = 8;

    logic               Clk_i = 1'b0;
    logic               Rstn_i;
    logic signed [47:0] Data_i;
    logic               DataValid_i;
    logic signed [17:0] Data_o;
    logic               DataValid_o;
    logic               DataReady_i;
    logic [3:0]         Level_o;
    logic               Sat_o;
    logic               Overflow_o;
    logic               ClearFlags_i;

    filter_output_formatter dut (
        .Clk_i        (Clk_i),
        .Rstn_i       (Rstn_i),
        .Data_i       (Data_i),
        .DataValid_i  (DataValid_i),
        .Data_o       (Data_o),
        .DataValid_o  (DataValid_o),
        .DataReady_i  (DataReady_i),
        .Level_o      (Level_o),
        .Sat_o        (Sat_o),
        .Overflow_o   (Overflow_o),
        .ClearFlags_i (ClearFlags_i)
    );

    always #5 Clk_i = ~Clk_i;

    typedef struct {
        bit     v;
        longint val;
        bit     clamp;
    } smp_t;

    smp_t   iq[$];
    longint mq[$];
    smp_t   d0, d1;
    bit     sat_m, ovf_m;
    int     n_cmp = 0;
    int     n_err = 0;

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: round(x / 2^17) then clamp to the signed 18-bit range.
    function automatic void fmt(input longint x, output longint y, output bit c);
        longint f, r, q;
        f = fdiv(x, SC);
        r = x - f * SC;
        q = fdiv(x + HALF, SC);
`ifdef FORMATTER_ROUND_CONVERGENT_EN
        if (r == HALF && (f % 2) == 0) q = f;
`endif
        c = 1'b0;
        if (q > MAXV) begin
            q = MAXV;
            c = 1'b1;
        end else if (q < MINV) begin
            q = MINV;
            c = 1'b1;
        end
        y = q;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input longint x, input bit rdy, input bit clr);
        smp_t s;
        @(posedge Clk_i);
        #1;
        DataValid_i  = v;
        Data_i       = x[47:0];
        DataReady_i  = rdy;
        ClearFlags_i = clr;
        s.v = v;
        fmt(x, s.val, s.clamp);
        iq.push_back(s);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 0, rdy, 1'b0);
    endtask

    task automatic rand_cycle();
        logic [63:0] r;
        longint x;
        int mode;
        mode = $urandom_range(0, 3);
        case (mode)
            0: begin
                r = {$urandom(), $urandom()};
                x = longint'($signed(r[47:0]));
            end
            1: x = longint'($urandom_range(0, 2097151)) - 1048576;
            2: x = (longint'($urandom_range(0, 400)) - 200) * SC + HALF;
            default: begin
                x = (longint'(1) <<< 34) + longint'($urandom_range(0, 524288)) - 262144;
                if ($urandom_range(0, 1) == 1) x = -x;
            end
        endcase
        drive($urandom_range(0, 3) != 0, x, $urandom_range(0, 2) != 0,
              $urandom_range(0, 15) == 0);
    endtask

    // Monitor: tracks the FIFO at sample level and compares every cycle.
    always @(negedge Clk_i) begin : mon
        smp_t   cur;
        bit     pop, set_sat, set_ovf;
        longint ev;
        cur = '{v: 1'b0, val: 0, clamp: 1'b0};
        if (iq.size() > 0) cur = iq.pop_front();
        if (!Rstn_i) begin
            mq.delete();
            d0 = '{v: 1'b0, val: 0, clamp: 1'b0};
            d1 = '{v: 1'b0, val: 0, clamp: 1'b0};
            sat_m = 1'b0;
            ovf_m = 1'b0;
        end
        ev = (mq.size() > 0) ? mq[0] : 0;
        chk("valid_o", longint'(DataValid_o), longint'(mq.size() > 0));
        chk("level_o", longint'(Level_o), longint'(mq.size()));
        chk("data_o", longint'(Data_o), ev);
        chk("sat_o", longint'(Sat_o), longint'(sat_m));
        chk("overflow_o", longint'(Overflow_o), longint'(ovf_m));
        if (Rstn_i) begin
            pop     = (mq.size() > 0) && DataReady_i;
            set_sat = d0.v && d0.clamp;
            set_ovf = 1'b0;
            if (pop) void'(mq.pop_front());
            if (d1.v) begin
                if (mq.size() < DEPTH) mq.push_back(d1.val);
                else set_ovf = 1'b1;
            end
            sat_m = set_sat ? 1'b1 : (ClearFlags_i ? 1'b0 : sat_m);
            ovf_m = set_ovf ? 1'b1 : (ClearFlags_i ? 1'b0 : ovf_m);
            d1 = d0;
            d0 = cur;
        end
    end

    initial begin
        longint rv [5];
        rv = '{131072, 65535, 65536, 196608, -65536};
        Rstn_i       = 1'b0;
        Data_i       = '0;
        DataValid_i  = 1'b0;
        DataReady_i  = 1'b1;
        ClearFlags_i = 1'b0;
        idle(3, 1'b1);
        #2 Rstn_i = 1'b1;
        idle(2, 1'b1);

        // Rounding cases, ready held high
        foreach (rv[i]) drive(1'b1, rv[i], 1'b1, 1'b0);
        idle(5, 1'b1);

        // Saturation both ways, then a clear
        drive(1'b1, longint'(1) <<< 34, 1'b1, 1'b0);
        drive(1'b1, -(longint'(1) <<< 40), 1'b1, 1'b0);
        idle(4, 1'b1);
        drive(1'b0, 0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Overflow: nine samples into an eight-deep FIFO with no reader
        for (int i = 1; i <= 9; i++) drive(1'b1, i * SC, 1'b0, 1'b0);
        idle(4, 1'b0);
        idle(12, 1'b1);
        drive(1'b0, 0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Push and pop on the same edge while full
        for (int i = 10; i < 18; i++) drive(1'b1, i * SC, 1'b0, 1'b0);
        idle(2, 1'b0);
        drive(1'b1, 99 * SC, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        idle(3, 1'b0);
        idle(12, 1'b1);

        // Continuous stream with a toggling reader
        for (int i = 0; i < 40; i++) drive(1'b1, (i + 1) * SC, i % 2 == 0, 1'b0);
        idle(30, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) rand_cycle();
        idle(20, 1'b1);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 11; i++) drive(1'b1, longint'(1) <<< 40, 1'b0, 1'b0);
        #2 Rstn_i = 1'b0;
        #1;
        chk("rst_valid_o", longint'(DataValid_o), 0);
        chk("rst_level_o", longint'(Level_o), 0);
        chk("rst_sat_o", longint'(Sat_o), 0);
        chk("rst_overflow_o", longint'(Overflow_o), 0);
        chk("rst_data_o", longint'(Data_o), 0);
        idle(2, 1'b1);
        #2 Rstn_i = 1'b1;
        drive(1'b1, 131072, 1'b1, 1'b0);
        idle(6, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter_output_formatter.md
Name: filter_output_formatter

Overview:
- Consumer stage for the systolic FIR filter output. Takes the 48-bit accumulator stream and its one-cycle valid strobe, then rounds, scales and saturates each sample to OutWidth bits.
- Results are buffered in a small FIFO that feeds a downstream valid/ready consumer.
- The filter has no backpressure, so the block absorbs bursts and flags any sample it drops.

Parameters:
- InWidth, 48, filter accumulator width.
- OutWidth, 18, output sample width (signed).
- Shift, 17, arithmetic right shift applied after rounding; range 1..InWidth-OutWidth.
- FifoDepth, 8, FIFO entries; power of 2, 2..64.

Ports:
- Clk_i  in  1  clock, rising edge.
- Rstn_i  in  1  asynchronous reset, active low.
- Data_i  in  InWidth  signed filter output sample.
- DataValid_i  in  1  Data_i valid this cycle; no ready returned.
- Data_o  out  OutWidth  signed formatted sample at FIFO head.
- DataValid_o  out  1  FIFO non-empty.
- DataReady_i  in  1  downstream accepts; a pop happens when DataValid_o && DataReady_i at the edge.
- Level_o  out  clog2(FifoDepth)+1  FIFO occupancy.
- Sat_o  out  1  sticky: at least one sample saturated.
- Overflow_o  out  1  sticky: at least one sample dropped because the FIFO was full.
- ClearFlags_i  in  1  synchronous clear of Sat_o and Overflow_o.

Behaviour:
- Reset (Rstn_i low, takes effect immediately without a clock):
  - pipeline valids, FIFO pointers and Level_o go to 0;
  - DataValid_o, Sat_o and Overflow_o go to 0;
  - Data_o goes to 0.
  - The rounding/saturation data registers are not reset.
- Stage 1 (edge E0, DataValid_i high): r1 <= (sext(Data_i, InWidth+1) + 2^(Shift-1)) >>> Shift. Rounding is half toward +infinity. The extra bit prevents wrap on the addition.
- Stage 2 (edge E1): saturate r1 to the signed OutWidth range.
  - Above 2^(OutWidth-1)-1: clamp to max.
  - Below -2^(OutWidth-1): clamp to min.
  - On any clamp, Sat_o is set at E1.
- FIFO write at edge E2. DataValid_o rises after E2, giving a fixed latency of 3 edges when the FIFO was empty.
- Back-to-back DataValid_i is supported at full rate (one sample per clock).
- FIFO is first-word-fall-through:
  - Data_o combinationally shows the head entry while DataValid_o is high;
  - Data_o is 0 while the FIFO is empty.
- Push and pop on the same edge:
  - allowed in any state, including full;
  - when full, the pop frees the slot and the push is accepted;
  - Level_o is unchanged.
- Push while full with no pop: the sample is discarded, Overflow_o is set, and the FIFO contents and order are unchanged.
- Pop while empty: ignored.
- Pointers are clog2(FifoDepth)+1 bits with wrap bit; full = addresses equal and wrap bits differ.
- Flag priority: if ClearFlags_i coincides with a new saturate or overflow event, the set wins and the flag stays 1.
- Reset mid-burst: all in-flight pipeline samples and FIFO contents are lost, and the first valid after release follows the 3-edge latency.

Optional Feature:
- Macro FORMATTER_ROUND_CONVERGENT_EN.
- Defined: round half to even. When the discarded bits are exactly 2^(Shift-1) and the kept LSB is 0, no increment is applied; otherwise behaviour is identical to the default.
- Undefined: round half toward +infinity, as above.
- Latency and ports are identical in both builds.

Test Plan (Shift=17, OutWidth=18, FifoDepth=8):
- Rounding, DataReady_i high:
  - inputs 131072, 65535, 65536, 196608, -65536 -> outputs 1, 0, 1, 2, 0;
  - with FORMATTER_ROUND_CONVERGENT_EN: 1, 0, 0, 2, 0;
  - each output appears 3 edges after its input.
- Saturation:
  - input 2^34 -> 131071 (0x1FFFF), Sat_o=1;
  - input -2^40 -> -131072 (0x20000);
  - pulse ClearFlags_i -> Sat_o=0 next cycle.
- Overflow: DataReady_i low, 9 consecutive valids carrying 1..9 (x131072)
  - -> Level_o=8, Overflow_o=1;
  - raise DataReady_i -> outputs 1..8 in order, one per clock, then DataValid_o=0 and Level_o=0.
- Simultaneous push/pop at full: FIFO full, DataReady_i high, one new valid
  - -> Level_o stays 8;
  - Overflow_o stays 0;
  - new sample appears 8th in order.
- Continuous stream with DataReady_i toggling 1/0 every cycle
  - -> no loss while Level_o < 8;
  - output order equals input order;
  - Level_o tracks pushes minus pops exactly.
- Async reset mid-burst: assert Rstn_i low between edges
  - -> DataValid_o, Level_o, Sat_o and Overflow_o read 0 before the next edge;
  - after release, a fresh sample of 131072 produces 1 after 3 edges.
